// File: rtl/regfile_alu_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr16_pkg
// Purpose  : Shared constants for the register-file / ALU datapath: ALU
//            function codes, full opcode encodings, processor-status flag bit
//            positions, the loadReg no-write encoding and small decode helpers.
// Optional : PSR_FLAGS_EN (consumed by regfile_alu_datapath)
// Revision : 1.0 - initial release
// ============================================================================
package cr16_pkg;

    // ALU function code. Register forms carry it in op[3:0] with op[7:4]=0;
    // immediate forms carry it in op[7:4].
    typedef enum logic [3:0] {
        FN_NONE = 4'h0,
        FN_AND  = 4'h1,
        FN_OR   = 4'h2,
        FN_XOR  = 4'h3,
        FN_ADD  = 4'h5,
        FN_SUB  = 4'h9,
        FN_CMP  = 4'hB,
        FN_MOV  = 4'hD
    } alu_fn_e;

    // Register-form opcodes
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;

    // Immediate-form opcodes (low nibble is don't-care)
    localparam logic [7:0] OP_ANDI = 8'h10;
    localparam logic [7:0] OP_ORI  = 8'h20;
    localparam logic [7:0] OP_XORI = 8'h30;
    localparam logic [7:0] OP_ADDI = 8'h50;
    localparam logic [7:0] OP_SUBI = 8'h90;
    localparam logic [7:0] OP_CMPI = 8'hB0;
    localparam logic [7:0] OP_MOVI = 8'hD0;

    // Processor-status flag bit positions within flags[4:0] = {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;
    localparam int NFLAGS = 5;

    // loadReg[4] set means the cycle performs no register write
    localparam int         LR_NOWRITE_BIT = 4;
    localparam logic [4:0] LR_NOWRITE     = 5'b1_0000;

    // True for the seven implemented function codes
    function automatic logic fn_valid(input logic [3:0] fn);
        logic v;
        case (fn)
            FN_AND, FN_OR, FN_XOR, FN_ADD, FN_SUB, FN_CMP, FN_MOV: v = 1'b1;
            default:                                               v = 1'b0;
        endcase
        return v;
    endfunction

    // Arithmetic and move treat Imm as signed; logical ops treat it as a mask
    function automatic logic fn_sign_ext(input logic [3:0] fn);
        logic s;
        case (fn)
            FN_ADD, FN_SUB, FN_CMP, FN_MOV: s = 1'b1;
            default:                        s = 1'b0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_alu_datapath_regfile16.sv
`default_nettype none
// ============================================================================
// Module   : regfile16
// Purpose  : NREGS x WIDTH register file with two combinational operand read
//            ports, one combinational display read port and one synchronous
//            write port. All registers clear asynchronously on clr.
// Ports    : clk, clr            - clock / async active-high clear
//            we, waddr, wdata    - write port (commits on rising clk)
//            raddr_a / rdata_a   - operand A read
//            raddr_b / rdata_b   - operand B read
//            raddr_d / rdata_d   - display read
// Revision : 1.0 - initial release
// ============================================================================
module regfile16 #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [AW-1:0]    raddr_d,
    output logic [WIDTH-1:0] rdata_d
);

    logic [WIDTH-1:0] rd_arr [NREGS];

    // One flop bank per register so each element has a single driver.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [WIDTH-1:0] reg_q;
        logic [WIDTH-1:0] reg_d;

        always_comb begin
            reg_d = reg_q;
            if (we && (waddr == AW'(gi))) begin
                reg_d = wdata;
            end
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rd_arr[gi] = reg_q;
    end

    // No write-to-read bypass: a write becomes visible after its edge.
    assign rdata_a = rd_arr[raddr_a];
    assign rdata_b = rd_arr[raddr_b];
    assign rdata_d = rd_arr[raddr_d];

endmodule
`default_nettype wire

// File: rtl/regfile_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_datapath
// Purpose  : Execution datapath: 16x16 register file, immediate mux/extender,
//            ALU and registered processor-status flags. One control word per
//            cycle; the result commits to the register file on the next edge.
// Ports    : clk, clr                       - clock / async active-high reset
//            selectImm, loadReg, readRegA,
//            readRegB, Imm, op              - control word
//            disp_sel / disp_data           - board display read port
//            alu_out                        - live combinational ALU result
//            result_q                       - last committed result
//            wr_valid                       - a write occurred on last edge
//            flags                          - {C,L,F,Z,N}
// Optional : PSR_FLAGS_EN - when defined the flags register is implemented;
//            otherwise flags read as 0 and no flag logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu_datapath
    import cr16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             selectImm,
    input  logic [4:0]       loadReg,
    input  logic [3:0]       readRegA,
    input  logic [3:0]       readRegB,
    input  logic [7:0]       Imm,
    input  logic [7:0]       op,
    input  logic [3:0]       disp_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] result_q,
    output logic             wr_valid,
    output logic [4:0]       flags,
    output logic [WIDTH-1:0] disp_data
);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_reg;
    logic             we;

    regfile16 #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (4)
    ) u_regfile (
        .clk     (clk),
        .clr     (clr),
        .we      (we),
        .waddr   (loadReg[3:0]),
        .wdata   (alu_out),
        .raddr_a (readRegA),
        .rdata_a (a_val),
        .raddr_b (readRegB),
        .rdata_b (b_reg),
        .raddr_d (disp_sel),
        .rdata_d (disp_data)
    );

    // ------------------------------------------------------------------
    // Decode and operand selection
    // ------------------------------------------------------------------
    logic             is_imm_form;
    logic [3:0]       fn;
    logic             op_valid;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] b_val;

    always_comb begin
        is_imm_form = (op[7:4] != 4'h0);
        fn          = is_imm_form ? op[7:4] : op[3:0];
        op_valid    = fn_valid(fn);
        // Extension follows the function, so a register form with
        // selectImm=1 extends the same way as its immediate twin.
        if (fn_sign_ext(fn)) begin
            imm_ext = {{(WIDTH-8){Imm[7]}}, Imm};
        end else begin
            imm_ext = {{(WIDTH-8){1'b0}}, Imm};
        end
        b_val = (selectImm || is_imm_form) ? imm_ext : b_reg;
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
`ifdef PSR_FLAGS_EN
    // One extra bit holds carry-out / borrow for the C flag.
    logic [WIDTH:0]   sum_full;
    logic [WIDTH:0]   diff_full;
    assign sum_full  = {1'b0, a_val} + {1'b0, b_val};
    assign diff_full = {1'b0, a_val} - {1'b0, b_val};
`else
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH-1:0] diff_full;
    assign sum_full  = a_val + b_val;
    assign diff_full = a_val - b_val;
`endif

    always_comb begin
        case (fn)
            FN_AND:         alu_out = a_val & b_val;
            FN_OR:          alu_out = a_val | b_val;
            FN_XOR:         alu_out = a_val ^ b_val;
            FN_ADD:         alu_out = sum_full[WIDTH-1:0];
            FN_SUB, FN_CMP: alu_out = diff_full[WIDTH-1:0];
            FN_MOV:         alu_out = b_val;
            default:        alu_out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Write commit
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_d;
    logic             wr_valid_d;
    logic             wr_valid_q;

    always_comb begin
        // CMP only exists for its flags; it never writes.
        we         = !loadReg[LR_NOWRITE_BIT] && op_valid && (fn != FN_CMP);
        wr_valid_d = we;
        result_d   = we ? alu_out : result_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            result_q   <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    assign wr_valid = wr_valid_q;

    // ------------------------------------------------------------------
    // Processor-status flags
    // ------------------------------------------------------------------
`ifdef PSR_FLAGS_EN
    logic [NFLAGS-1:0] flags_d;
    logic [NFLAGS-1:0] flags_q;
    logic              is_add;
    logic              is_sub;
    logic [WIDTH-1:0]  res_w;

    always_comb begin
        is_add  = (fn == FN_ADD);
        is_sub  = (fn == FN_SUB) || (fn == FN_CMP);
        res_w   = alu_out;
        flags_d = flags_q;
        if (is_add || is_sub) begin
            if (is_add) begin
                flags_d[FLAG_C] = sum_full[WIDTH];
                // Same-sign operands producing a different-sign result
                flags_d[FLAG_F] = (a_val[WIDTH-1] == b_val[WIDTH-1]) &&
                                  (res_w[WIDTH-1] != a_val[WIDTH-1]);
            end else begin
                flags_d[FLAG_C] = diff_full[WIDTH];
                // Opposite-sign operands where the result sign flips from A
                flags_d[FLAG_F] = (a_val[WIDTH-1] != b_val[WIDTH-1]) &&
                                  (res_w[WIDTH-1] != a_val[WIDTH-1]);
            end
            flags_d[FLAG_Z] = (fn == FN_CMP) ? (a_val == b_val) : (res_w == '0);
            flags_d[FLAG_L] = (a_val < b_val);
            flags_d[FLAG_N] = ($signed(a_val) < $signed(b_val));
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_alu_datapath
// Purpose  : Self-checking bench for regfile_alu_datapath. A behavioural
//            model predicts each cycle's commit; predictions are queued when
//            the control word is driven and compared after the clock edge.
// Optional : PSR_FLAGS_EN (must match the DUT build)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_alu_datapath;
    import cr16_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        selectImm;
    logic [4:0]  loadReg;
    logic [3:0]  readRegA;
    logic [3:0]  readRegB;
    logic [7:0]  Imm;
    logic [7:0]  op;
    logic [3:0]  disp_sel;
    logic [15:0] alu_out;
    logic [15:0] result_q;
    logic        wr_valid;
    logic [4:0]  flags;
    logic [15:0] disp_data;

    regfile_alu_datapath #(.WIDTH(16), .NREGS(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .selectImm (selectImm),
        .loadReg   (loadReg),
        .readRegA  (readRegA),
        .readRegB  (readRegB),
        .Imm       (Imm),
        .op        (op),
        .disp_sel  (disp_sel),
        .alu_out   (alu_out),
        .result_q  (result_q),
        .wr_valid  (wr_valid),
        .flags     (flags),
        .disp_data (disp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic        wr_valid;
        logic [4:0]  flags;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_reg [16];
    logic [15:0] m_result;
    logic [4:0]  m_flags;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef PSR_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
        m_result = 16'h0;
        m_flags  = 5'h0;
    endtask

    // Independent arithmetic model using integer math.
    task automatic model_op(input logic si, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [7:0] imm, input logic [7:0] opc,
                            output logic [15:0] res, output logic can_wr,
                            output logic upd, output logic [4:0] nf);
        logic [3:0]  f;
        logic        imf;
        logic [15:0] a, b, immx;
        int          ia, ib, sa, sbv, t, st;
        logic        c, l, fo, z, n;
        imf  = (opc[7:4] != 4'h0);
        f    = imf ? opc[7:4] : opc[3:0];
        immx = (f == 4'h5 || f == 4'h9 || f == 4'hB || f == 4'hD) ?
               {{8{imm[7]}}, imm} : {8'h00, imm};
        a    = m_reg[ra];
        b    = (si || imf) ? immx : m_reg[rb];
        ia   = int'(a);
        ib   = int'(b);
        sa   = int'($signed(a));
        sbv  = int'($signed(b));
        res = 16'h0; can_wr = 1'b1; upd = 1'b0;
        c = 1'b0; fo = 1'b0;
        case (f)
            4'h1: res = a & b;
            4'h2: res = a | b;
            4'h3: res = a ^ b;
            4'h5: begin
                t = ia + ib; res = t[15:0]; c = (t > 65535);
                st = sa + sbv; fo = (st > 32767) || (st < -32768); upd = 1'b1;
            end
            4'h9, 4'hB: begin
                t = ia - ib; res = t[15:0]; c = (ia < ib);
                st = sa - sbv; fo = (st > 32767) || (st < -32768); upd = 1'b1;
                if (f == 4'hB) can_wr = 1'b0;
            end
            4'hD: res = b;
            default: begin res = 16'h0; can_wr = 1'b0; end
        endcase
        z  = (f == 4'hB) ? (a == b) : (res == 16'h0);
        l  = (ia < ib);
        n  = (sa < sbv);
        nf = {c, l, fo, z, n};
        upd = upd && FLAGS_ON;
    endtask

    task automatic step(input logic si, input logic [4:0] lr, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [7:0] imm, input logic [7:0] opc);
        exp_t        e;
        logic [15:0] res;
        logic        can_wr, upd, wr;
        logic [4:0]  nf;
        @(negedge clk);
        selectImm = si; loadReg = lr; readRegA = ra; readRegB = rb; Imm = imm; op = opc;
        model_op(si, ra, rb, imm, opc, res, can_wr, upd, nf);
        #1;
        check_eq("alu_out", 32'(alu_out), 32'(res));
        wr         = !lr[4] && can_wr;
        e.wr_valid = wr;
        e.result   = wr ? res : m_result;
        e.flags    = upd ? nf : m_flags;
        sb_q.push_back(e);
        if (wr) m_reg[lr[3:0]] = res;
        m_result = e.result;
        m_flags  = e.flags;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("result_q", 32'(result_q), 32'(e.result));
        check_eq("wr_valid", 32'(wr_valid), 32'(e.wr_valid));
        check_eq("flags",    32'(flags),    32'(e.flags));
    endtask

    // Park the control word on a no-op so edges during the sweep change nothing.
    task automatic check_regs(input string tag);
        loadReg = LR_NOWRITE; op = 8'h00; selectImm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            disp_sel = 4'(i);
            #1;
            check_eq(tag, 32'(disp_data), 32'(m_reg[i]));
        end
    endtask

    task automatic read_reg(input logic [3:0] idx, output logic [15:0] v);
        disp_sel = idx;
        #1;
        v = disp_data;
    endtask

    logic [3:0] fns [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [4:0]  flags_hold;
        clr = 1'b1; selectImm = 1'b0; loadReg = LR_NOWRITE; readRegA = 4'h0;
        readRegB = 4'h0; Imm = 8'h00; op = 8'h00; disp_sel = 4'h0;
        model_reset();
        #1;
        check_eq("rst_result_q", 32'(result_q), 32'h0);
        check_eq("rst_wr_valid", 32'(wr_valid), 32'h0);
        check_eq("rst_flags",    32'(flags),    32'h0);
        check_regs("rst_reg");
        @(negedge clk);
        clr = 1'b0;

        // ---------------- Fibonacci ----------------
        step(1'b0, 5'd0, 4'd1, 4'd0, 8'h01, OP_ADDI);
        step(1'b0, 5'd1, 4'd2, 4'd0, 8'h01, OP_ADDI);
        for (int n = 2; n < 16; n++)
            step(1'b0, 5'(n), 4'(n - 1), 4'(n - 2), 8'h00, OP_ADD);
        step(1'b0, LR_NOWRITE, 4'd15, 4'd14, 8'h00, OP_OR);
        check_eq("fib_wr_valid_last", 32'(wr_valid), 32'h0);
        read_reg(4'd15, v);
        check_eq("fib_r15", 32'(v), 32'd987);
        read_reg(4'd14, v);
        check_eq("fib_r14", 32'(v), 32'd610);
        check_regs("fib_reg");

        // ---------------- Overflow ----------------
        step(1'b0, 5'd1, 4'd0, 4'd0, 8'h7F, OP_MOVI);
        for (int k = 0; k < 8; k++) step(1'b0, 5'd1, 4'd1, 4'd1, 8'h00, OP_ADD);
        step(1'b0, 5'd1, 4'd1, 4'd0, 8'hFF, OP_ORI);
        check_eq("ovf_r1", 32'(result_q), 32'h7FFF);
        step(1'b0, 5'd2, 4'd0, 4'd0, 8'h01, OP_MOVI);
        step(1'b0, 5'd3, 4'd1, 4'd2, 8'h00, OP_ADD);
        check_eq("ovf_sum", 32'(result_q), 32'h8000);
        check_eq("ovf_F", 32'(flags[FLAG_F]), 32'(FLAGS_ON));
        check_eq("ovf_C", 32'(flags[FLAG_C]), 32'h0);
        step(1'b0, 5'd4, 4'd0, 4'd0, 8'hFF, OP_MOVI);
        step(1'b0, 5'd5, 4'd4, 4'd2, 8'h00, OP_ADD);
        check_eq("wrap_sum", 32'(result_q), 32'h0000);
        check_eq("wrap_C", 32'(flags[FLAG_C]), 32'(FLAGS_ON));
        check_eq("wrap_Z", 32'(flags[FLAG_Z]), 32'(FLAGS_ON));

        // ---------------- CMP ----------------
        step(1'b0, 5'd3, 4'd0, 4'd0, 8'h05, OP_MOVI);
        step(1'b0, 5'd4, 4'd0, 4'd0, 8'hFF, OP_MOVI);
        step(1'b0, 5'd6, 4'd3, 4'd4, 8'h00, OP_CMP);
        check_eq("cmp_wr_valid", 32'(wr_valid), 32'h0);
        check_eq("cmp_LNZ", 32'({flags[FLAG_L], flags[FLAG_N], flags[FLAG_Z]}),
                 32'(FLAGS_ON ? 3'b100 : 3'b000));
        step(1'b0, 5'd6, 4'd3, 4'd0, 8'h05, OP_CMPI);
        check_eq("cmpi_Z", 32'(flags[FLAG_Z]), 32'(FLAGS_ON));
        check_regs("cmp_reg");

        // ---------------- Immediate extension ----------------
        step(1'b0, 5'd5, 4'd0, 4'd0, 8'h10, OP_MOVI);
        step(1'b0, 5'd5, 4'd5, 4'd0, 8'hFF, OP_ADDI);
        check_eq("addi_sext", 32'(result_q), 32'h000F);
        step(1'b0, 5'd6, 4'd0, 4'd0, 8'h00, OP_MOVI);
        step(1'b0, 5'd6, 4'd6, 4'd0, 8'hFF, OP_ORI);
        check_eq("ori_zext", 32'(result_q), 32'h00FF);
        // Register form forced onto Imm by selectImm
        step(1'b1, 5'd7, 4'd6, 4'd15, 8'h80, OP_MOV);
        check_eq("mov_selimm", 32'(result_q), 32'hFF80);

        // ---------------- Unknown op ----------------
        flags_hold = m_flags;
        step(1'b0, 5'd8, 4'd1, 4'd2, 8'h00, 8'h04);
        check_eq("unk_wr_valid", 32'(wr_valid), 32'h0);
        check_eq("unk_flags_hold", 32'(flags), 32'(flags_hold));

        // ---------------- Random traffic ----------------
        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [7:0]  ropc;
            sel = $urandom_range(0, 15);
            if (sel < 7)       ropc = {4'h0, fns[$urandom_range(0, 6)]};
            else if (sel < 14) ropc = {fns[$urandom_range(0, 6)], 4'($urandom_range(0, 15))};
            else               ropc = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), ropc);
        end
        check_regs("rand_reg");

        // ---------------- Async reset with a pending write ----------------
        @(negedge clk);
        selectImm = 1'b0; loadReg = 5'd7; readRegA = 4'd0; readRegB = 4'd0;
        Imm = 8'h33; op = OP_MOVI;
        #2;
        clr = 1'b1;
        #1;
        check_eq("clr_result_q", 32'(result_q), 32'h0);
        check_eq("clr_wr_valid", 32'(wr_valid), 32'h0);
        check_eq("clr_flags",    32'(flags),    32'h0);
        model_reset();
        @(posedge clk);
        #1;
        read_reg(4'd7, v);
        check_eq("clr_abort_r7", 32'(v), 32'h0);
        check_regs("clr_reg");
        @(negedge clk);
        clr = 1'b0;
        step(1'b0, 5'd9, 4'd0, 4'd0, 8'h2A, OP_MOVI);
        check_regs("post_clr_reg");

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_alu_datapath.md
Name: regfile_alu_datapath

Overview:
- Execution datapath driven directly by the sequencer FSM: 16x16 register file, immediate mux, ALU and processor-status flags.
- Each cycle it consumes the control word (selectImm, loadReg, readRegA, readRegB, Imm, op), computes combinationally and commits the result on the next clk edge.
- Exposes the live ALU output, the last committed result and a board display read port.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 16, register count; readRegA, readRegB and disp_sel index it with 4 bits.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- selectImm  in  1  forces the B operand to the extended Imm.
- loadReg  in  5  write control: bit4=1 means no write; otherwise [3:0] is the destination.
- readRegA  in  4  A operand register index.
- readRegB  in  4  B operand register index.
- Imm  in  8  immediate value.
- op  in  8  opcode; [7:4]=0 is register form with function in [3:0], [7:4]!=0 is immediate form.
- disp_sel  in  4  display read index.
- alu_out  out  WIDTH  combinational ALU result.
- result_q  out  WIDTH  last value written to the register file.
- wr_valid  out  1  registered pulse: a register write occurred on the previous edge.
- flags  out  5  {C,L,F,Z,N}, registered.
- disp_data  out  WIDTH  combinational read of reg[disp_sel].

Behaviour:
- Reset (async, clr=1): all registers, result_q, wr_valid and flags clear to 0 immediately. clr asserted mid-sequence aborts any pending write.
- Reads: A=reg[readRegA] and B=reg[readRegB] are combinational. There is no bypass; a write is visible on the cycle after its edge. r0 is an ordinary writable register.
- B operand: use Imm if selectImm=1 OR op[7:4]!=0; otherwise use reg[readRegB].
- Imm extension: sign-extended for ADDI, SUBI, CMPI, MOVI; zero-extended for ANDI, ORI, XORI.
- Register forms, op = 0000_xxxx:
  - AND 0x01, OR 0x02, XOR 0x03, ADD 0x05, SUB 0x09, CMP 0x0B, MOV 0x0D.
  - If the B mux selects Imm, the register form operates on the immediate.
- Immediate forms, keyed on op[7:4], op[3:0] ignored: ANDI 1, ORI 2, XORI 3, ADDI 5, SUBI 9, CMPI B, MOVI D.
- ALU results:
  - ADD: A+B, truncated to WIDTH.
  - SUB: A-B.
  - MOV: B.
  - CMP: alu_out = A-B, but no register write.
- Unknown op: alu_out=0, no write, flags hold.
- Write: on a clk edge, if loadReg[4]=0, the op is valid and not CMP, then reg[loadReg[3:0]] <= alu_out, result_q <= alu_out and wr_valid <= 1. Otherwise wr_valid <= 0 and result_q holds.
- Flags, updated only by ADD/SUB/CMP and their immediate forms; all other ops hold them:
  - C: carry-out of ADD; borrow of SUB/CMP.
  - F: signed overflow.
  - Z: A==B for CMP, result==0 otherwise.
  - L: A<B unsigned.
  - N: A<B signed.
- Latency: one edge from control word to register commit. Back-to-back dependent ops need no stall, because the FSM advances one state per clock.
- Wrap-around: arithmetic is modulo 2^WIDTH; overflow is reported only via C and F.

Optional Feature:
- Macro: PSR_FLAGS_EN.
- Defined: flags register implemented as above.
- Undefined: flags tied to 0, no flag logic synthesized. CMP/CMPI become no-ops with no write, and alu_out still shows A-B.

Decomposition:
- Package cr16_pkg holds:
  - opcode and function constants, including ADD=8'h05, ADDI=8'h50, OR=8'h02;
  - flag bit indices C=4, L=3, F=2, Z=1, N=0;
  - the no-write encoding for loadReg bit4.
- One sub-module, regfile16:
  - two combinational read ports plus the display port;
  - one synchronous write port with async clear.
- ALU and flags logic stay in the top module.

Test Plan:
- Reset: assert clr mid-run, between edges → result_q, flags, wr_valid and all registers read via disp_sel are 0 with no clock edge needed.
- Fibonacci sequence, 17 cycles: ADDI r0=r1+1, ADDI r1=r2+1 with selectImm=0, then ADD r(n)=r(n-1)+r(n-2) for n=2..15, then OR with loadReg=5'b10000 → r15=987 (0x03DB), r14=610; final cycle has wr_valid=0 and r15 unchanged.
- Overflow (PSR_FLAGS_EN): ADD with 0x7FFF + 0x0001 → 0x8000 with F=1, C=0. Then ADD 0xFFFF + 0x0001 → 0x0000 with C=1, Z=1.
- CMP: r3=5, r4=0xFFFF, CMP A=r3 B=r4 → L=1, N=0, Z=0, no write, wr_valid=0. Then CMPI A=r3, Imm=8'h05 → Z=1.
- Immediate extension: ADDI Imm=8'hFF to r5=0x0010 → 0x000F. ORI Imm=8'hFF to r6=0 → 0x00FF.
- Build without PSR_FLAGS_EN: repeat the overflow test → flags stay 5'b0 and results are identical.
